// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response collector: FSM states and default sizing.
package puf_pkg;

  localparam int unsigned DEF_RESP_BITS = 32;
  localparam int unsigned DEF_VOTES     = 15;
  localparam int unsigned DEF_SETTLE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_RELAX  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: launches a race VOTES times per bit and
// majority-votes the synchronized arbiter output into a RESP_BITS response word.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS = DEF_RESP_BITS,
  parameter int unsigned VOTES     = DEF_VOTES,
  parameter int unsigned SETTLE    = DEF_SETTLE
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic                                                arb_q,
  output logic                                                race_launch,
  output logic [((RESP_BITS > 1) ? $clog2(RESP_BITS) : 1)-1:0] chal_idx,
  output logic                                                busy,
  output logic                                                resp_valid,
  input  logic                                                resp_ready,
  output logic [RESP_BITS-1:0]                                resp_data,
  output logic [$clog2(RESP_BITS+1)-1:0]                      unstable_cnt
);

  localparam int unsigned IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned UNST_W = $clog2(RESP_BITS + 1);
  localparam int unsigned VOTE_W = $clog2(VOTES + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE + 1);

  if ((VOTES % 2) == 0) begin : g_bad_votes
    $error("puf_response_collector: VOTES must be odd and >= 1");
  end
  if (SETTLE < 3) begin : g_bad_settle
    $error("puf_response_collector: SETTLE must be >= 3");
  end

  state_e               state_q, state_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [VOTE_W-1:0]    votes_q, votes_d;
  logic [VOTE_W-1:0]    ones_q, ones_d;
  logic [VOTE_W-1:0]    votes_inc, ones_inc;
  logic                 bit_done_q, bit_done_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic [UNST_W-1:0]    unst_q, unst_d;
  logic                 launch_q, launch_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 arb_sync;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d_i (arb_q),
    .q_o (arb_sync)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      votes_q    <= '0;
      ones_q     <= '0;
      bit_done_q <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      unst_q     <= '0;
      launch_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      votes_q    <= votes_d;
      ones_q     <= ones_d;
      bit_done_q <= bit_done_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      unst_q     <= unst_d;
      launch_q   <= launch_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state, vote accumulation and registered-output decode
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    votes_d    = votes_q;
    ones_d     = ones_q;
    bit_done_d = bit_done_q;
    idx_d      = idx_q;
    data_d     = data_q;
    unst_d     = unst_q;
    votes_inc  = votes_q + VOTE_W'(1);
    ones_inc   = ones_q + VOTE_W'(arb_sync);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LAUNCH;
          settle_d   = '0;
          votes_d    = '0;
          ones_d     = '0;
          bit_done_d = 1'b0;
          idx_d      = '0;
          data_d     = '0;
          unst_d     = '0;
        end
      end
      ST_LAUNCH: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        state_d = ST_RELAX;
        if (votes_inc == VOTE_W'(VOTES)) begin
          data_d[idx_q] = (ones_inc > VOTE_W'(VOTES / 2));
          if ((ones_inc != '0) && (ones_inc != VOTE_W'(VOTES))) begin
            unst_d = unst_q + UNST_W'(1);
          end
          votes_d    = '0;
          ones_d     = '0;
          bit_done_d = 1'b1;
        end else begin
          votes_d = votes_inc;
          ones_d  = ones_inc;
        end
      end
      ST_RELAX: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          settle_d   = '0;
          bit_done_d = 1'b0;
          state_d    = ST_LAUNCH;
          // The last bit finishes the word; chal_idx is left on it rather than wrapping
          if (bit_done_q) begin
            if (idx_q == IDX_W'(RESP_BITS - 1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    launch_d = (state_d == ST_LAUNCH) || (state_d == ST_SAMPLE);
    busy_d   = (state_d != ST_IDLE);
    valid_d  = (state_d == ST_DONE);
  end

  assign race_launch  = launch_q;
  assign busy         = busy_q;
  assign resp_valid   = valid_q;
  assign chal_idx     = idx_q;
  assign resp_data    = data_q;
  assign unstable_cnt = unst_q;

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 SHALL have parameter RESP_BITS, default 32: number of response bits per word.
REQ-002 SHALL have parameter VOTES, default 15: evaluations per response bit; odd, >=1; an even value SHALL fail elaboration.
REQ-003 SHALL have parameter SETTLE, default 8: cycles per launch/relax phase; >=3; a smaller value SHALL fail elaboration.
REQ-004 SHALL have port clk  input  1  the single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one response word; sampled only in IDLE.
REQ-007 SHALL have port arb_q  input  1  arbiter flip-flop output, asynchronous to clk.
REQ-008 SHALL have port race_launch  output  1  drives both race-path inputs of the delay chain.
REQ-009 SHALL have port chal_idx  output  clog2(RESP_BITS)  index of the bit under evaluation; the upstream challenge source derives its challenge from it.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port resp_valid  output  1  response word available.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts the word.
REQ-013 SHALL have port resp_data  output  RESP_BITS  voted response; bit i is the result for chal_idx=i.
REQ-014 SHALL have port unstable_cnt  output  clog2(RESP_BITS+1)  count of bits in the word whose votes were not unanimous.

Function
REQ-015 SHALL synchronize arb_q through two flip-flops; only the synchronized value is sampled.
REQ-016 SHALL implement states IDLE, LAUNCH, SAMPLE, RELAX, DONE.
REQ-017 IDLE with start=1 SHALL go to LAUNCH next cycle, clearing chal_idx, the vote counter, the ones counter, resp_data and unstable_cnt.
REQ-018 LAUNCH SHALL hold race_launch=1 for exactly SETTLE cycles, then go to SAMPLE.
REQ-019 SAMPLE (1 cycle, race_launch=1) SHALL add the synchronized arb_q to the ones counter and increment the vote counter.
REQ-020 On the VOTES-th sample of a bit: resp_data[chal_idx] SHALL be set to (ones > VOTES/2); unstable_cnt SHALL be incremented unless ones is 0 or VOTES; ones and vote counters SHALL be cleared.
REQ-021 RELAX SHALL hold race_launch=0 for exactly SETTLE cycles, then go to LAUNCH. After the final vote of bit RESP_BITS-1 it SHALL go to DONE instead. chal_idx SHALL increment on exit from RELAX after a bit completes.
REQ-022 Per vote: 2*SETTLE+1 cycles. With start accepted at cycle t, resp_valid SHALL rise at t+1+RESP_BITS*VOTES*(2*SETTLE+1).
REQ-023 DONE SHALL hold resp_valid=1, with resp_data and unstable_cnt stable, until resp_ready=1; it SHALL then go to IDLE, with resp_valid=0 the next cycle.
REQ-024 start SHALL be ignored outside IDLE, including in the DONE cycle that completes the handshake.
REQ-025 resp_ready SHALL be ignored outside DONE.
REQ-026 race_launch SHALL be 0 in IDLE and DONE.
REQ-027 Counter widths: votes and ones clog2(VOTES+1); no counter SHALL wrap within a word.

Reset
REQ-028 rst=1 SHALL, on the next rising edge and from any state: enter IDLE; set race_launch, busy and resp_valid to 0; set chal_idx, resp_data and unstable_cnt to 0; clear counters and synchronizer flops.
REQ-029 Reset mid-word SHALL discard partial results; rst has priority over start.

Structure
REQ-030 Shared package puf_pkg SHALL hold the state enum and the default RESP_BITS/VOTES/SETTLE constants.
REQ-031 The two-flop synchronizer SHALL be a sub-module, sync2.

Verification (RESP_BITS=4, VOTES=3, SETTLE=3, start at cycle 0)
REQ-032 arb_q tied 1 -> resp_valid rises at cycle 85; resp_data=4'hF; unstable_cnt=0; exactly 12 race_launch rising edges.
REQ-033 arb_q = chal_idx[0] (held constant per bit) -> resp_data=4'hA; unstable_cnt=0.
REQ-034 arb_q=1 on 2 of 3 votes for bit 2, 0 elsewhere -> resp_data=4'h4; unstable_cnt=1.
REQ-035 resp_ready low for 10 cycles after valid, with start pulses -> valid/data held, starts ignored; ready=1 -> resp_valid=0 and busy=0 next cycle.
REQ-036 rst pulse at cycle 40 -> next cycle race_launch=0, busy=0, outputs 0; a new start yields the full correct word 85 cycles later.
